// File: rtl/updown_counter.sv
// updown_counter: loadable up/down binary counter with enable and terminal count.
// Optional: define UPDOWN_COUNTER_SATURATE_EN to pin at the limits instead of wrapping.
//
// Ports:
//   i_clk    clock, state changes on the rising edge
//   i_rst_n  asynchronous active-low reset (count -> 0)
//   i_en     count enable
//   i_load   parallel load strobe (highest priority)
//   i_up     direction, 1 = increment, 0 = decrement
//   i_d      parallel load value
//   o_q      current count
//   o_qn     bitwise inverse of o_q
//   o_tc     terminal count, combinational; chains to the next stage's i_en
module updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic             i_up,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qn,
  output logic             o_tc
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic             at_max;
  logic             at_min;
  logic             do_load;
  logic             do_inc;
  logic             do_dec;

  assign at_max  = &q;
  assign at_min  = ~|q;

  // Mutually exclusive selects so the decoder stays one-hot.
  assign do_load = i_load;
  assign do_inc  = ~i_load & i_en & i_up;
  assign do_dec  = ~i_load & i_en & ~i_up;

  always_comb begin
    q_nxt = q;
    unique case (1'b1)
      do_load: q_nxt = i_d;
`ifdef UPDOWN_COUNTER_SATURATE_EN
      do_inc:  q_nxt = at_max ? q : q + 1'b1;
      do_dec:  q_nxt = at_min ? q : q - 1'b1;
`else
      do_inc:  q_nxt = q + 1'b1;
      do_dec:  q_nxt = q - 1'b1;
`endif
      default: q_nxt = q;
    endcase
  end

  // Edge-triggered register: the master/slave pair of the storage stage,
  // so input glitches while the clock is low never reach the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q <= '0;
    end else begin
      q <= q_nxt;
    end
  end

  assign o_q  = q;
  assign o_qn = ~q;

  // High in the cycle before a wrap so a cascaded stage counts on that edge.
  assign o_tc = i_rst_n & i_en & ~i_load &
                ((i_up & at_max) | (~i_up & at_min));

endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: directed vectors with a scoreboard queue and negedge monitor.
// Covers reset, wrap, load priority, terminal count, cascade and saturation.
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       load;
  logic       up;
  logic [3:0] din;
  logic [3:0] q;
  logic [3:0] qn;
  logic       tc;

  logic       c_rst_n;
  logic       c_en;
  logic [3:0] lo_q;
  logic [3:0] lo_qn;
  logic       lo_tc;
  logic [3:0] hi_q;
  logic [3:0] hi_qn;
  logic       hi_tc;

`ifdef UPDOWN_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    bit         kind;
    logic [7:0] v;
    logic       tc;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(4)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_en   (en),
    .i_load (load),
    .i_up   (up),
    .i_d    (din),
    .o_q    (q),
    .o_qn   (qn),
    .o_tc   (tc)
  );

  updown_counter #(.WIDTH(4)) u_lo (
    .i_clk  (clk),
    .i_rst_n(c_rst_n),
    .i_en   (c_en),
    .i_load (1'b0),
    .i_up   (1'b1),
    .i_d    (4'h0),
    .o_q    (lo_q),
    .o_qn   (lo_qn),
    .o_tc   (lo_tc)
  );

  updown_counter #(.WIDTH(4)) u_hi (
    .i_clk  (clk),
    .i_rst_n(c_rst_n),
    .i_en   (lo_tc),
    .i_load (1'b0),
    .i_up   (1'b1),
    .i_d    (4'h0),
    .o_q    (hi_q),
    .o_qn   (hi_qn),
    .o_tc   (hi_tc)
  );

  // Monitor: the DUT presents a settled value every falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (e.kind == 1'b0) begin
        if (q !== e.v[3:0] || qn !== ~e.v[3:0] || tc !== e.tc) begin
          bad++;
          $display("FAIL %s: q=%h qn=%h tc=%b required q=%h qn=%h tc=%b",
                   e.nm, q, qn, tc, e.v[3:0], ~e.v[3:0], e.tc);
        end
      end else begin
        if ({hi_q, lo_q} !== e.v) begin
          bad++;
          $display("FAIL %s: count=%h required %h", e.nm, {hi_q, lo_q}, e.v);
        end
      end
    end
  end

  task automatic apply(input logic r, input logic e, input logic l,
                       input logic u, input logic [3:0] d,
                       input logic [3:0] eq, input logic et,
                       input string nm);
    @(posedge clk);
    #1;
    rst_n = r;
    en    = e;
    load  = l;
    up    = u;
    din   = d;
    sb.push_back('{kind: 1'b0, v: {4'h0, eq}, tc: et, nm: nm});
  endtask

  task automatic cstep(input logic e, input logic [7:0] ev);
    @(posedge clk);
    #1;
    c_rst_n = 1'b1;
    c_en    = e;
    sb.push_back('{kind: 1'b1, v: ev, tc: 1'b0, nm: "cascade"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    load    = 1'b0;
    up      = 1'b0;
    din     = 4'h0;
    c_rst_n = 1'b0;
    c_en    = 1'b0;

    // Reset gates tc even though q=0 and counting down.
    apply(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, "rst_init");

    // Up count over a full wrap.
    for (int i = 0; i < 17; i++) begin
      apply(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'(i),
            (4'(i) == 4'hF), "up_count");
    end

    // Down count through zero.
    apply(1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 4'h1, 1'b0, "load_2");
    apply(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h2, 1'b0, "down_2");
    apply(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h1, 1'b0, "down_1");
    apply(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, "down_0");

    // Load wins over enable; tc suppressed even at all ones.
    apply(1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 4'hF, 1'b0, "down_wrap_ld");
    apply(1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 4'h5, 1'b0, "load_prio");
    apply(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'hA, 1'b0, "load_val");

    // Asynchronous reset mid-cycle from 9.
    apply(1'b1, 1'b0, 1'b1, 1'b0, 4'h9, 4'hA, 1'b0, "load_9");
    apply(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h9, 1'b0, "hold_9");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    en    = 1'b1;
    up    = 1'b0;
    sb.push_back('{kind: 1'b0, v: 8'h00, tc: 1'b0, nm: "rst_async"});
    apply(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, "rst_hold");
    apply(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, "rst_hold");
    apply(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, "rst_release");

    // Upper limit: wrap or saturate.
    apply(1'b1, 1'b0, 1'b1, 1'b0, 4'hE, 4'h1, 1'b0, "load_E");
    apply(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'hE, 1'b0, "lim_up_E");
    apply(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'hF, 1'b1, "lim_up_F");
    apply(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, SAT ? 4'hF : 4'h0, SAT,
          "lim_up_next");
    apply(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, SAT ? 4'hF : 4'h1, 1'b0,
          "lim_up_last");

    // Lower limit: wrap or saturate.
    apply(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, "lim_dn_0");
    apply(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, SAT ? 4'h0 : 4'hF, 1'b0,
          "lim_dn_next");

    // Two-stage cascade over 256 edges.
    for (int n = 0; n <= 256; n++) begin
      cstep(1'b1, 8'(n));
    end
    cstep(1'b0, 8'h01);

    repeat (2) @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
